// File: rtl/dmem_arbiter_pkg.sv
// Shared owner encoding, default slice lengths and bus widths for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  localparam int unsigned DMEM_ADDR_W   = 16;
  localparam int unsigned DMEM_DATA_W   = 32;
  localparam int unsigned CPU_SLICE_DEF = 4;
  localparam int unsigned EXT_SLICE_DEF = 1;

endpackage

// File: rtl/dmem_slice_counter.sv
// Owner flag and slice counter: decides who owns the data-memory port next cycle.
module dmem_slice_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned CPU_SLICE = CPU_SLICE_DEF,
  parameter int unsigned EXT_SLICE = EXT_SLICE_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic ext_req,
  output logic owner
);

  localparam int unsigned MAX_SLICE = (CPU_SLICE > EXT_SLICE) ? CPU_SLICE : EXT_SLICE;
  localparam int unsigned CNT_W     = $clog2(MAX_SLICE) + 1;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      cur_slice;

  // Owner and counter registers; reset parks the port on the core.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_CPU;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next owner: a lone requester always wins; under contention the owner keeps
  // the port until its slice is used up.
  always_comb begin
    owner_d   = OWN_CPU;
    cnt_d     = '0;
    cnt_inc   = cnt_q + 1'b1;
    cur_slice = (owner_q == OWN_EXT) ? 32'(EXT_SLICE) : 32'(CPU_SLICE);
    if (cpu_req && ext_req) begin
      if (32'(cnt_inc) >= cur_slice) begin
        owner_d = (owner_q == OWN_EXT) ? OWN_CPU : OWN_EXT;
        cnt_d   = '0;
      end else begin
        owner_d = owner_q;
        cnt_d   = cnt_inc;
      end
    end else if (ext_req) begin
      owner_d = OWN_EXT;
    end else begin
      owner_d = OWN_CPU;
    end
  end

  assign owner = owner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port sharing between the core load/store path and an external
// loader/debug port. The registered owner steers the datapath with no added latency.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned CPU_SLICE = CPU_SLICE_DEF,
  parameter int unsigned EXT_SLICE = EXT_SLICE_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  logic own_ext;
  logic owner_req;
  logic owner_we;

  dmem_slice_counter #(
    .CPU_SLICE (CPU_SLICE),
    .EXT_SLICE (EXT_SLICE)
  ) u_slice_counter (
    .clock   (clock),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .ext_req (ext_req),
    .owner   (own_ext)
  );

  // Datapath mux. Reset gates the strobes and read data directly so nothing
  // reaches the memory while rst_n is low, and a requesting core is held off.
  always_comb begin
    owner_req = own_ext ? ext_req   : cpu_req;
    owner_we  = own_ext ? ext_we    : cpu_we;
    mem_addr  = own_ext ? ext_addr  : cpu_addr;
    mem_wdata = own_ext ? ext_wdata : cpu_wdata;
    mem_write = rst_n & owner_req & owner_we;
    mem_read  = rst_n & owner_req & ~owner_we;
    ext_ack   = rst_n & ext_req & own_ext;
    cpu_stall = cpu_req & (~rst_n | own_ext);
    cpu_rdata = (rst_n && !own_ext && cpu_req) ? mem_rdata : '0;
    ext_rdata = ext_ack ? mem_rdata : '0;
  end

  assign owner = own_ext;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (16-bit word address, 32-bit data, combinational read, write on clock edge) between the core's load/store path and an external loader/debug port.
- Sits between the core (memRead/memWrite, alu_result[15:0], read_data_2) and the data memory.
- Grants one owner per cycle using a registered owner flag and slice counters.
- Stalls the core when it is denied.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 32, data width
- CPU_SLICE, 4, maximum consecutive core accesses under contention before yielding (>=1)
- EXT_SLICE, 1, maximum consecutive external accesses under contention before yielding (>=1)

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  core memory access request (memRead|memWrite)
- cpu_we  in  1  core write enable (1 = store)
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core store data
- cpu_rdata  out  DATA_W  core load data
- cpu_stall  out  1  core must hold PC and state this cycle
- ext_req  in  1  external request; held until ext_ack
- ext_we  in  1  external write enable
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_rdata  out  DATA_W  external read data, valid when ext_ack
- ext_ack  out  1  external access performed this cycle
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_write  out  1  to data memory
- mem_read  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory (combinational)
- owner  out  1  current grant: 0 = CPU, 1 = EXT

Behaviour:
State:
- owner register (0 = CPU, 1 = EXT).
- cnt register, width clog2(max(CPU_SLICE, EXT_SLICE)) + 1.
- Reset (rst_n low, asynchronous): owner = CPU (park), cnt = 0.
- While rst_n is low: mem_write = 0, mem_read = 0, ext_ack = 0, cpu_stall = cpu_req, rdata outputs = 0.

Access cycle (combinational from the registered owner):
- The owner's request muxes onto mem_addr/mem_wdata.
- mem_write = owner_req & owner_we; mem_read = owner_req & ~owner_we.
- When no access occurs, mem_addr/mem_wdata follow the owner's inputs and both strobes are 0.
- cpu_rdata = mem_rdata when owner = CPU and cpu_req, else 0.
- ext_rdata = mem_rdata when ext_ack, else 0.
- cpu_stall = cpu_req & (owner = EXT).
- ext_ack = ext_req & (owner = EXT).
- Zero added latency for the owner; a denied requester waits at least 1 cycle.

Next owner, evaluated at each rising edge:
- Neither requesting: owner -> CPU, cnt -> 0.
- Only cpu_req: owner -> CPU, cnt -> 0.
- Only ext_req: owner -> EXT, cnt -> 0.
  - From a CPU park, the first external access therefore occurs 1 cycle after ext_req rises.
- Both requesting, owner has cnt+1 >= its slice: switch owner, cnt -> 0.
- Both requesting, otherwise: keep owner, cnt -> cnt+1.

Boundary cases:
- Owner drops its request mid-slice: switch on the next edge if the other side requests; cnt -> 0.
- Sustained contention with defaults gives the repeating pattern CPU, CPU, CPU, CPU, EXT.
- A slice of 1 alternates every cycle.
- Writes commit on the same edge the grant is evaluated. The memory sees the write of the current owner only.
- Reset asserted mid-slice: grant returns to CPU immediately; no write strobe while reset is low.
- Addresses pass through untruncated. Address range and bounds are the memory's responsibility.

Decomposition:
- Shared package:
  - OWN_CPU = 1'b0, OWN_EXT = 1'b1
  - default CPU_SLICE/EXT_SLICE
  - DMEM_ADDR_W = 16, DMEM_DATA_W = 32
- One sub-module, dmem_slice_counter: owns the owner/cnt registers and next-owner logic.
  - Inputs: cpu_req, ext_req.
  - Output: owner.
- The top level is the datapath muxing.

Test Plan:
1. Reset, then cpu_req=1, cpu_we=1, addr 0x0010, wdata 0xDEADBEEF, ext_req=0 -> cpu_stall=0, mem_write=1 same cycle; next cycle a core read of 0x0010 returns cpu_rdata=0xDEADBEEF with no stall.
2. Idle, then ext_req=1 write 0x0004 = 0x12345678 -> cycle 0: ext_ack=0, owner=0. Cycle 1: owner=1, ext_ack=1, mem_write=1. Core read of 0x0004 afterwards = 0x12345678.
3. cpu_req and ext_req held high for 10 cycles (defaults) -> owner sequence 0,0,0,0,1,0,0,0,0,1; cpu_stall high only in the owner=1 cycles; ext_ack high exactly twice.
4. Owner=EXT, ext_req drops while cpu_req=1 -> next cycle owner=0, cnt=0, cpu_stall=0.
5. rst_n pulled low mid-contention with owner=EXT and ext_we=1 -> owner=0 immediately (asynchronous), mem_write=0 while low; after release the first cycle serves the core.
6. CPU_SLICE=1, EXT_SLICE=1, both requesting -> owner alternates 0,1,0,1 every cycle.
